ram_fifo_ctrl: RTL

Single-clock FIFO controller that drives the team's 16×8 single-port synchronous RAM (`we`, `addr`, `din`, `dout`). It turns the RAM into a 16-entry queue with a valid/ready stream on each side. It sits directly upstream of the RAM, owning every RAM port cycle. Because the RAM is single-port, the controller grants at most one access per cycle, either a write or a read.

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_fifo_ptr.sv | 20 ++
 rtl/ram_fifo_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the 16x8 single-port RAM and its FIFO controller.
package ram_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Word count held in RAM (0..DEPTH) needs one bit more than an address.
    typedef logic [ADDR_W:0]   cnt_t;

    // Total occupancy including output register and in-flight read (0..DEPTH+1).
    typedef logic [ADDR_W+1:0] lvl_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping RAM address pointer: advances by one on inc, wraps modulo DEPTH.
module ram_fifo_ptr
    import ram_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    output addr_t ptr
);

    // Natural binary wrap of an ADDR_W-bit register gives the modulo-DEPTH behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + addr_t'(1);
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping a single-port synchronous RAM into a 16-entry
// valid/ready queue with a registered output word.
// Optional build macro: RAM_FIFO_STATUS_EN adds level/empty/full outputs.
module ram_fifo_ctrl
    import ram_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  s_valid,
    output logic  s_ready,
    input  data_t s_data,
    output logic  m_valid,
    input  logic  m_ready,
    output data_t m_data,
    output logic  ram_we,
    output addr_t ram_addr,
    output data_t ram_din,
    input  data_t ram_dout
`ifdef RAM_FIFO_STATUS_EN
    ,
    output lvl_t  level,
    output logic  empty,
    output logic  full
`endif
);

    addr_t wr_ptr;
    addr_t rd_ptr;
    cnt_t  count;
    logic  rd_pend;
    logic  rd_go;
    logic  wr_go;

    // The RAM port is shared: a read wins whenever the output register will be
    // free to take its data one cycle later; otherwise the port is offered to
    // the writer. RAM data is only trusted in the cycle after a read issue,
    // so read-during-write output is never captured.
    always_comb begin
        rd_go    = (count != '0) && !rd_pend && (!m_valid || m_ready);
        s_ready  = (count != CNT_FULL) && !rd_go;
        wr_go    = s_valid && s_ready;
        ram_we   = wr_go;
        ram_addr = wr_go ? wr_ptr : rd_ptr;
        ram_din  = s_data;
    end

    ram_fifo_ptr u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_go),
        .ptr (wr_ptr)
    );

    ram_fifo_ptr u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_go),
        .ptr (rd_ptr)
    );

    // Words resident in RAM; a read and a write never share a cycle, so the
    // count moves by at most one per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (rd_go) begin
            count <= count - cnt_t'(1);
        end else if (wr_go) begin
            count <= count + cnt_t'(1);
        end
    end

    // Marks the cycle in which the RAM presents the data of last cycle's read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_go;
        end
    end

    // Output register: loads returning read data, empties on consumption.
    // A read is only issued when this register is empty or being drained,
    // so a capture never overwrites an unconsumed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (rd_pend) begin
            m_valid <= 1'b1;
            m_data  <= ram_dout;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

`ifdef RAM_FIFO_STATUS_EN
    // Occupancy seen from outside: RAM contents plus the word in flight and
    // the word held at the output.
    always_comb begin
        level = lvl_t'(count) + lvl_t'(m_valid) + lvl_t'(rd_pend);
        empty = (level == '0);
        full  = (count == CNT_FULL);
    end
`endif

endmodule
